rx_pid_crc_decoder: RTL and testbench

- Receive-side back end of the USB-style serial link. Input is the NRZI-decoded, bit-unstuffed serial stream, framed by start/end strobes.
- Stage 1 (bit-stream decoder) validates the 8-bit PID and forwards the stream to stage 2 one cycle later.
- Stage 2 (CRC receiver) captures PID and 64-bit payload, checks CRC16, and reports packet status until software acknowledges.

---
 rtl/rx_pid_crc_decoder.sv | 152 +++++++++++++++
 tb/tb_rx_pid_crc_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rx_pid_crc_decoder.sv
// rx_pid_crc_decoder: PID validation, one-cycle forwarding and CRC16 packet check for the serial receive path
module rx_pid_crc_decoder #(
  parameter int DATA_BITS = 64,
  parameter int CRC_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_decode,
  input  logic                 end_decode,
  input  logic                 s_in,
  input  logic                 rc_PIDerror,
  input  logic                 rc_CRCerror,
  input  logic                 pkt_rec,
  output logic                 PID_error,
  output logic                 CRC_error,
  output logic                 pkt_status,
  output logic [7:0]           rc_hshake,
  output logic [DATA_BITS-1:0] rc_data,
  output logic                 start_rc_crc,
  output logic                 end_rc_crc
);
  localparam int FRAME_BITS = DATA_BITS + CRC_BITS;
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT  = CW'(FRAME_BITS + 1);
  typedef enum logic [1:0] {D_IDLE, D_PID, D_FWD, D_ABORT} dec_t;
  typedef enum logic [2:0] {C_IDLE, C_PID, C_DATA, C_CHECK, C_HOLD} crc_t;
  dec_t                  dec_state;
  logic [2:0]            dec_cnt;
  logic [6:0]            dec_pid;
  logic [7:0]            pid_full;
  logic                  pid_ok;
  logic                  s_out;
  logic                  abort;
  crc_t                  crc_state;
  logic [CW-1:0]         cnt;
  logic [7:0]            pid_st;
  logic [FRAME_BITS-1:0] stage;
  logic [15:0]           crc;
  logic [15:0]           crc_next;
  logic                  chk_err;
  // First received PID bit lands in [7]; both accepted types need b1 set and a matching check nibble
  always_comb begin
    pid_full = {dec_pid, s_in};
    pid_ok   = (pid_full[3:0] == ~pid_full[7:4]) && pid_full[6];
    crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ s_out) ? 16'h8005 : 16'h0000);
    chk_err  = pid_st[7] ? (cnt != FULL || crc != 16'h800D) : (cnt != '0);
  end
  // Stage 1: PID validation, abort tracking and the one-cycle forwarding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_state    <= D_IDLE;
      dec_cnt      <= '0;
      dec_pid      <= '0;
      s_out        <= 1'b0;
      abort        <= 1'b0;
      start_rc_crc <= 1'b0;
      end_rc_crc   <= 1'b0;
      PID_error    <= 1'b0;
    end else begin
      s_out        <= s_in;
      start_rc_crc <= start_decode;
      end_rc_crc   <= end_decode;
      if (rc_PIDerror) PID_error <= 1'b0;
      if (start_decode) begin
        dec_state <= D_PID;
        dec_cnt   <= '0;
        abort     <= 1'b0;
      end else begin
        case (dec_state)
          D_IDLE: dec_state <= D_IDLE;
          D_PID: begin
            if (end_decode) dec_state <= D_IDLE;
            else begin
              dec_pid <= pid_full[6:0];
              dec_cnt <= dec_cnt + 3'd1;
              if (dec_cnt == 3'd7) begin
                dec_state <= pid_ok ? D_FWD : D_ABORT;
                if (!pid_ok) begin
                  abort     <= 1'b1;
                  PID_error <= 1'b1;
                end
              end
            end
          end
          default: if (end_decode) dec_state <= D_IDLE;
        endcase
      end
    end
  end
  // Stage 2: PID capture, CRC16 over payload plus CRC field, one-cycle check, then hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_state  <= C_IDLE;
      cnt        <= '0;
      pid_st     <= '0;
      stage      <= '0;
      crc        <= '0;
      CRC_error  <= 1'b0;
      pkt_status <= 1'b0;
      rc_hshake  <= '0;
      rc_data    <= '0;
    end else begin
      if (rc_CRCerror) CRC_error <= 1'b0;
      case (crc_state)
        C_IDLE: begin
          if (start_rc_crc) begin
            crc_state <= C_PID;
            cnt       <= '0;
          end
        end
        C_PID: begin
          if (start_rc_crc) cnt <= '0;
          else if (end_rc_crc) crc_state <= C_IDLE;
          else begin
            pid_st <= {pid_st[6:0], s_out};
            cnt    <= (cnt == CW'(7)) ? '0 : cnt + 1'b1;
            if (cnt == CW'(7)) begin
              crc_state <= C_DATA;
              crc       <= 16'hFFFF;
            end
          end
        end
        C_DATA: begin
          if (start_rc_crc) begin
            crc_state <= C_PID;
            cnt       <= '0;
          end else if (end_rc_crc) crc_state <= abort ? C_IDLE : C_CHECK;
          else begin
            stage <= {stage[FRAME_BITS-2:0], s_out};
            crc   <= crc_next;
            cnt   <= (cnt == SAT) ? cnt : cnt + 1'b1;
          end
        end
        C_CHECK: begin
          rc_hshake  <= pid_st;
          if (pid_st[7]) rc_data <= stage[FRAME_BITS-1:CRC_BITS];
          if (chk_err) CRC_error <= 1'b1;
          pkt_status <= 1'b1;
          crc_state  <= C_HOLD;
        end
        C_HOLD: begin
          if (pkt_rec) begin
            pkt_status <= 1'b0;
            crc_state  <= C_IDLE;
          end
        end
        default: crc_state <= C_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_pid_crc_decoder.sv
// tb_rx_pid_crc_decoder: directed frames with hand-computed expectations for rx_pid_crc_decoder
module tb_rx_pid_crc_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_decode = 1'b0;
  logic end_decode = 1'b0;
  logic s_in = 1'b0;
  logic rc_PIDerror = 1'b0;
  logic rc_CRCerror = 1'b0;
  logic pkt_rec = 1'b0;
  logic PID_error, CRC_error, pkt_status, start_rc_crc, end_rc_crc;
  logic [7:0] rc_hshake;
  logic [63:0] rc_data;
  int n_assert = 0;
  int n_fail = 0;
  localparam logic [63:0] PAYLOAD = 64'hF77DB57B7D5D7F53;
  localparam logic [87:0] GOOD    = {8'hC3, 64'hF77DB57B7D5D7F53, 16'hDBC5};
  localparam logic [87:0] BADCRC  = {8'hC3, 64'hF77DB57B7D5D7F53, 16'hDBC4};

  rx_pid_crc_decoder dut (
    .clk(clk), .rst_n(rst_n), .start_decode(start_decode), .end_decode(end_decode),
    .s_in(s_in), .rc_PIDerror(rc_PIDerror), .rc_CRCerror(rc_CRCerror), .pkt_rec(pkt_rec),
    .PID_error(PID_error), .CRC_error(CRC_error), .pkt_status(pkt_status),
    .rc_hshake(rc_hshake), .rc_data(rc_data),
    .start_rc_crc(start_rc_crc), .end_rc_crc(end_rc_crc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [127:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      s_in = bits[n-1-i];
      tick();
    end
    s_in = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] bits, input int n);
    start_decode = 1'b1;
    tick();
    start_decode = 1'b0;
    send_bits(bits, n);
    end_decode = 1'b1;
    tick();
    end_decode = 1'b0;
  endtask

  task automatic settle();
    tick();
    tick();
    @(negedge clk);
  endtask

  task automatic pulse_rec();
    tick();
    pkt_rec = 1'b1;
    tick();
    pkt_rec = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_crc_ack();
    tick();
    rc_CRCerror = 1'b1;
    tick();
    rc_CRCerror = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pid_err", 64'(PID_error), 64'd0);
    check("rst_crc_err", 64'(CRC_error), 64'd0);
    check("rst_status", 64'(pkt_status), 64'd0);
    check("rst_hshake", 64'(rc_hshake), 64'd0);
    check("rst_data", rc_data, 64'd0);
    check("rst_start_rc", 64'(start_rc_crc), 64'd0);
    check("rst_end_rc", 64'(end_rc_crc), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    send_frame(128'(GOOD), 88);
    settle();
    check("d0_status", 64'(pkt_status), 64'd1);
    check("d0_hshake", 64'(rc_hshake), 64'hC3);
    check("d0_data", rc_data, PAYLOAD);
    check("d0_pid_err", 64'(PID_error), 64'd0);
    check("d0_crc_err", 64'(CRC_error), 64'd0);
    pulse_rec();
    check("d0_rec_status", 64'(pkt_status), 64'd0);

    send_frame(128'(BADCRC), 88);
    settle();
    check("bc_status", 64'(pkt_status), 64'd1);
    check("bc_crc_err", 64'(CRC_error), 64'd1);
    pulse_rec();
    check("bc_rec_status", 64'(pkt_status), 64'd0);
    check("bc_sticky", 64'(CRC_error), 64'd1);
    pulse_crc_ack();
    check("bc_ack", 64'(CRC_error), 64'd0);

    send_frame(128'({8'hC2, 16'hA5F0}), 24);
    settle();
    check("bp_pid_err", 64'(PID_error), 64'd1);
    check("bp_status", 64'(pkt_status), 64'd0);
    check("bp_crc_err", 64'(CRC_error), 64'd0);
    check("bp_hshake", 64'(rc_hshake), 64'hC3);
    tick();
    rc_PIDerror = 1'b1;
    tick();
    rc_PIDerror = 1'b0;
    @(negedge clk);
    check("bp_ack", 64'(PID_error), 64'd0);

    send_frame(128'(8'h4B), 8);
    settle();
    check("ack_status", 64'(pkt_status), 64'd1);
    check("ack_hshake", 64'(rc_hshake), 64'h4B);
    check("ack_crc_err", 64'(CRC_error), 64'd0);
    check("ack_data_kept", rc_data, PAYLOAD);
    pulse_rec();
    check("ack_rec", 64'(pkt_status), 64'd0);

    end_decode = 1'b1;
    tick();
    end_decode = 1'b0;
    settle();
    check("idle_end", 64'(pkt_status), 64'd0);
    check("idle_end_err", 64'(CRC_error), 64'd0);

    send_frame(128'(GOOD >> 10), 78);
    settle();
    check("tr_status", 64'(pkt_status), 64'd1);
    check("tr_crc_err", 64'(CRC_error), 64'd1);
    pulse_rec();
    pulse_crc_ack();
    check("tr_ack", 64'(CRC_error), 64'd0);

    send_frame({38'd0, GOOD, 2'b10}, 90);
    settle();
    check("ol_status", 64'(pkt_status), 64'd1);
    check("ol_crc_err", 64'(CRC_error), 64'd1);
    pulse_rec();
    pulse_crc_ack();

    start_decode = 1'b1;
    tick();
    start_decode = 1'b0;
    send_bits(128'(GOOD >> 68), 20);
    send_frame(128'(8'h4B), 8);
    settle();
    check("rs_status", 64'(pkt_status), 64'd1);
    check("rs_hshake", 64'(rc_hshake), 64'h4B);
    check("rs_crc_err", 64'(CRC_error), 64'd0);
    check("rs_pid_err", 64'(PID_error), 64'd0);

    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_status", 64'(pkt_status), 64'd0);
    check("ar_hshake", 64'(rc_hshake), 64'd0);
    check("ar_data", rc_data, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
